// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared state encoding and output-mux select codes for the NPU sequencer
package npu_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_RELU    = 3'd3,
        S_CAPTURE = 3'd4,
        S_WRITE   = 3'd5,
        S_SHIFT   = 3'd6,
        S_FINISH  = 3'd7
    } state_e;

    localparam logic [2:0] SEL_FIFO = 3'b000;
    localparam logic [2:0] SEL_PISO = 3'b001;

endpackage

// File: rtl/npu_byte_serializer.sv
// rtl/npu_byte_serializer.sv - lane snapshot and byte mux, lane 0 first, MSB byte first per lane
module npu_byte_serializer #(
    parameter int N_LANES = 2,
    parameter int ACC_W   = 16,
    parameter int BYTE_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_LANES*ACC_W-1:0]   din,
    input  logic                       load,
    input  logic                       advance,
    output logic                       last,
    output logic [BYTE_W-1:0]          dout
);

    localparam int NB   = N_LANES * ACC_W / BYTE_W;
    localparam int BPL  = ACC_W / BYTE_W;
    localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;

    logic [N_LANES*ACC_W-1:0] snap_q;
    logic [BI_W-1:0]          bi_q;
    logic [BYTE_W-1:0]        ordered [NB];

    // Byte b lives in lane b/BPL; within a lane the first byte sent is the top one.
    for (genvar b = 0; b < NB; b++) begin : g_order
        assign ordered[b] = snap_q[(b / BPL) * ACC_W + ACC_W - ((b % BPL) + 1) * BYTE_W +: BYTE_W];
    end

    assign dout = ordered[bi_q];
    assign last = (bi_q == BI_W'(NB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
            bi_q   <= '0;
        end else if (load) begin
            snap_q <= din;
            bi_q   <= '0;
        end else if (advance) begin
            bi_q <= bi_q + BI_W'(1);
        end
    end

endmodule

// File: rtl/npu_seq_ctrl.sv
// rtl/npu_seq_ctrl.sv - NPU job sequencer: load, N-cycle MAC, ReLU, byte serialisation, PISO strobe
module npu_seq_ctrl
    import npu_pkg::*;
#(
    parameter int N_LANES = 2,
    parameter int ACC_W   = 16,
    parameter int BYTE_W  = 8,
    parameter int CNT_W   = 8
) (
    input  logic                     CLKEXT,
    input  logic                     RST_GLO,
    input  logic                     START,
    input  logic                     ABORT,
    input  logic [CNT_W-1:0]         CFG_MAC_CYCLES,
    input  logic                     CFG_BYPASS_RELU,
    input  logic [N_LANES*ACC_W-1:0] LANE_RES,
    input  logic                     FIFO_FULL,
    output logic                     EN_BUF_IN,
    output logic                     EN_MAC,
    output logic                     RST_MAC,
    output logic                     EN_RELU,
    output logic                     BYPASS_RELU,
    output logic                     FIFO_WR_EN,
    output logic [BYTE_W-1:0]        FIFO_DIN,
    output logic                     EN_PISO_OUT,
    output logic                     SHIFT_OUT,
    output logic [2:0]               SEL_OUT,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     ERR_ABORT
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] m_q;
    logic             byp_q;
    logic             err_q;
    logic             start_s0_q, start_q1_q, start_q2_q;
    logic             start_pls;
    logic             abort_hit;
    logic             wr_en;
    logic             ser_last;
    logic [BYTE_W-1:0] ser_dout;

    // s0 is the synchroniser stage; the edge is taken between q1 and q2.
    assign start_pls = start_q1_q & ~start_q2_q;
    assign abort_hit = ABORT && (state_q != S_IDLE) && (state_q != S_FINISH);
    assign wr_en     = (state_q == S_WRITE) && !FIFO_FULL;

    npu_byte_serializer #(
        .N_LANES (N_LANES),
        .ACC_W   (ACC_W),
        .BYTE_W  (BYTE_W)
    ) u_ser (
        .clk     (CLKEXT),
        .rst_n   (RST_GLO),
        .din     (LANE_RES),
        .load    (state_q == S_CAPTURE),
        .advance (wr_en),
        .last    (ser_last),
        .dout    (ser_dout)
    );

    always_ff @(posedge CLKEXT or negedge RST_GLO) begin
        if (!RST_GLO) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            m_q        <= '0;
            byp_q      <= 1'b0;
            err_q      <= 1'b0;
            start_s0_q <= 1'b0;
            start_q1_q <= 1'b0;
            start_q2_q <= 1'b0;
        end else begin
            start_s0_q <= START;
            start_q1_q <= start_s0_q;
            start_q2_q <= start_q1_q;
            err_q      <= 1'b0;
            if (abort_hit) begin
                state_q <= S_IDLE;
                err_q   <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE:    if (start_pls) state_q <= S_LOAD;
                    S_LOAD: begin
                        m_q     <= (CFG_MAC_CYCLES == '0) ? CNT_W'(1) : CFG_MAC_CYCLES;
                        byp_q   <= CFG_BYPASS_RELU;
                        cnt_q   <= '0;
                        state_q <= S_COMPUTE;
                    end
                    S_COMPUTE: begin
                        if (cnt_q == m_q - CNT_W'(1)) state_q <= S_RELU;
                        else                          cnt_q   <= cnt_q + CNT_W'(1);
                    end
                    S_RELU:    state_q <= S_CAPTURE;
                    S_CAPTURE: state_q <= S_WRITE;
                    S_WRITE:   if (wr_en && ser_last) state_q <= S_SHIFT;
                    S_SHIFT:   state_q <= S_FINISH;
                    S_FINISH:  state_q <= S_IDLE;
                    default:   state_q <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        EN_BUF_IN   = 1'b0;
        EN_MAC      = 1'b0;
        RST_MAC     = 1'b0;
        EN_RELU     = 1'b0;
        BYPASS_RELU = 1'b0;
        FIFO_WR_EN  = 1'b0;
        FIFO_DIN    = '0;
        EN_PISO_OUT = 1'b0;
        SHIFT_OUT   = 1'b0;
        SEL_OUT     = SEL_FIFO;
        BUSY        = 1'b1;
        DONE        = 1'b0;
        ERR_ABORT   = err_q;
        case (state_q)
            S_IDLE: begin
                RST_MAC = 1'b1;
                BUSY    = 1'b0;
            end
            // The bypass bit is not latched until LOAD ends, so LOAD shows the live input.
            S_LOAD: begin
                EN_BUF_IN   = 1'b1;
                RST_MAC     = 1'b1;
                BYPASS_RELU = CFG_BYPASS_RELU;
            end
            S_COMPUTE: begin
                EN_MAC      = 1'b1;
                BYPASS_RELU = byp_q;
            end
            S_RELU: begin
                EN_RELU     = 1'b1;
                BYPASS_RELU = byp_q;
            end
            S_CAPTURE: BYPASS_RELU = byp_q;
            S_WRITE: begin
                BYPASS_RELU = byp_q;
                FIFO_WR_EN  = wr_en;
                FIFO_DIN    = ser_dout;
            end
            S_SHIFT: begin
                BYPASS_RELU = byp_q;
                EN_PISO_OUT = 1'b1;
                SHIFT_OUT   = 1'b1;
                SEL_OUT     = SEL_PISO;
            end
            S_FINISH: begin
                BYPASS_RELU = byp_q;
                RST_MAC     = 1'b1;
                DONE        = 1'b1;
            end
            default: begin
                RST_MAC = 1'b1;
                BUSY    = 1'b0;
            end
        endcase
    end

endmodule
